// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data memory controller.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  localparam int DEF_DATA_W = 32;
  localparam int LANES      = DEF_DATA_W / 8;

  // Widest word byte_merge handles; callers zero-extend and truncate.
  localparam int MAX_DATA_W = 512;
  localparam int MAX_LANES  = MAX_DATA_W / 8;

  function automatic logic [MAX_DATA_W-1:0] byte_merge(
    input logic [MAX_DATA_W-1:0] old_w,
    input logic [MAX_DATA_W-1:0] new_w,
    input logic [MAX_LANES-1:0]  en
  );
    logic [MAX_DATA_W-1:0] r;
    r = old_w;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (en[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_store.sv
// Word array: combinational read port, posedge write port.
module dmem_store #(
  parameter int DW    = 32,
  parameter int WORDS = 2048,
  parameter int AW    = 11
) (
  input  logic          clk_i,
  input  logic [AW-1:0] rd_idx_i,
  output logic [DW-1:0] rd_data_o,
  input  logic          we_i,
  input  logic [AW-1:0] wr_idx_i,
  input  logic [DW-1:0] wr_data_i
);

  logic [DW-1:0] mem_q [WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[wr_idx_i] <= wr_data_i;
  end

  // Non-power-of-two depths leave holes in the index space; read those as zero.
  assign rd_data_o = (32'(rd_idx_i) < WORDS) ? mem_q[rd_idx_i] : '0;

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: valid/ready request and response channels,
// byte-lane writes, programmable wait states and address-error responses.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_BIT_WIDTH = 32,
  parameter int DMEMADDRBITS   = 13,
  parameter int DMEMWORDBITS   = 2,
  parameter int DMEMWORDS      = 2048,
  parameter int WAIT_CYCLES    = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        reqValid,
  output logic                        reqReady,
  input  logic                        reqWrite,
  input  logic [DATA_BIT_WIDTH-1:0]   reqAddr,
  input  logic [DATA_BIT_WIDTH-1:0]   reqWrData,
  input  logic [DATA_BIT_WIDTH/8-1:0] reqByteEn,
  output logic                        respValid,
  input  logic                        respReady,
  output logic [DATA_BIT_WIDTH-1:0]   respData,
  output logic                        respErr
);

  localparam int DW     = DATA_BIT_WIDTH;
  localparam int NLANES = DW / 8;
  localparam int IDX_W  = DMEMADDRBITS - DMEMWORDBITS;
  localparam int AW     = (DMEMWORDS > 1) ? $clog2(DMEMWORDS) : 1;
  localparam logic [DW-1:0] OFF_MASK = DW'((64'd1 << DMEMWORDBITS) - 64'd1);

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              write_q;
  logic              err_q;
  logic [AW-1:0]     idx_q;
  logic [DW-1:0]     wdata_q;
  logic [NLANES-1:0] be_q;
  logic              rvalid_q;
  logic [DW-1:0]     rdata_q;
  logic              rerr_q;

  logic [IDX_W-1:0]  req_idx;
  logic              req_err;
  logic [DW-1:0]     rd_word;
  logic [DW-1:0]     merged_d;
  logic              access;
  logic              mem_we;

  assign req_idx = reqAddr[DMEMADDRBITS-1:DMEMWORDBITS];
  assign req_err = ((reqAddr & OFF_MASK) != '0)
                || (32'(req_idx) >= DMEMWORDS)
                || ((reqAddr >> DMEMADDRBITS) != '0);

  assign access   = (state_q == BUSY) && (cnt_q == 4'd0);
  assign merged_d = DW'(byte_merge(MAX_DATA_W'(rd_word), MAX_DATA_W'(wdata_q),
                                   MAX_LANES'(be_q)));
  // Reset landing on the access edge must not commit the write.
  assign mem_we   = access && write_q && !err_q && !reset;

  dmem_store #(
    .DW    (DW),
    .WORDS (DMEMWORDS),
    .AW    (AW)
  ) u_store (
    .clk_i     (clk),
    .rd_idx_i  (idx_q),
    .rd_data_o (rd_word),
    .we_i      (mem_we),
    .wr_idx_i  (idx_q),
    .wr_data_i (merged_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (reqValid) begin
            write_q <= reqWrite;
            err_q   <= req_err;
            idx_q   <= req_idx[AW-1:0];
            wdata_q <= reqWrData;
            be_q    <= reqByteEn;
            cnt_q   <= 4'(WAIT_CYCLES);
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            if (err_q) begin
              rdata_q <= '0;
              rerr_q  <= 1'b1;
            end else begin
              rdata_q <= write_q ? merged_d : rd_word;
              rerr_q  <= 1'b0;
            end
            rvalid_q <= 1'b1;
            state_q  <= RESP;
          end
        end
        RESP: begin
          if (respReady) begin
            rvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign reqReady  = (state_q == IDLE);
  assign respValid = rvalid_q;
  assign respData  = rdata_q;
  assign respErr   = rerr_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomised bench for data_mem_ctrl: a 32-bit/2-wait and a 64-bit/0-wait
// instance share one request bus, checked against a word-level memory model.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        reqValid, reqWrite, respReady;
  logic [63:0] reqAddr, reqWrData;
  logic [7:0]  reqByteEn;

  logic        rdy32, rv32, re32, rdy64, rv64, re64;
  logic [31:0] rd32;
  logic [63:0] rd64;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] mem_m [int];

  always #5 clk = ~clk;

  data_mem_ctrl u_dut32 (
    .clk       (clk),
    .reset     (reset),
    .reqValid  (reqValid & ~sel),
    .reqReady  (rdy32),
    .reqWrite  (reqWrite),
    .reqAddr   (reqAddr[31:0]),
    .reqWrData (reqWrData[31:0]),
    .reqByteEn (reqByteEn[3:0]),
    .respValid (rv32),
    .respReady (respReady & ~sel),
    .respData  (rd32),
    .respErr   (re32)
  );

  data_mem_ctrl #(
    .DATA_BIT_WIDTH (64),
    .DMEMADDRBITS   (13),
    .DMEMWORDBITS   (3),
    .DMEMWORDS      (512),
    .WAIT_CYCLES    (0)
  ) u_dut64 (
    .clk       (clk),
    .reset     (reset),
    .reqValid  (reqValid & sel),
    .reqReady  (rdy64),
    .reqWrite  (reqWrite),
    .reqAddr   (reqAddr),
    .reqWrData (reqWrData),
    .reqByteEn (reqByteEn),
    .respValid (rv64),
    .respReady (respReady & sel),
    .respData  (rd64),
    .respErr   (re64)
  );

  wire        rdy  = sel ? rdy64 : rdy32;
  wire        rv   = sel ? rv64  : rv32;
  wire        rerr = sel ? re64  : re32;
  wire [63:0] rdat = sel ? rd64  : {32'd0, rd32};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (sel=%0d) got=%0h exp=%0h", tag, sel, got, exp);
    end
  endtask

  function automatic int wb();    return sel ? 8 : 4;      endfunction
  function automatic int waits(); return sel ? 0 : 2;      endfunction
  function automatic int words(); return sel ? 512 : 2048; endfunction

  function automatic bit model_err(input logic [63:0] a);
    return (a % 64'(wb()) != 0) || (a >= 64'd8192) || ((a / 64'(wb())) >= 64'(words()));
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n,
                                        input logic [7:0] be);
    logic [63:0] r;
    r = o;
    for (int i = 0; i < wb(); i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic int key_of(input logic [63:0] a);
    return (sel ? 100000 : 0) + int'(a / 64'(wb()));
  endfunction

  // One full transaction; hold = cycles respReady stays low in RESP with reqValid driven.
  task automatic txn(input bit wr, input logic [63:0] addr, input logic [63:0] data,
                     input logic [7:0] be, input int hold);
    int lat;
    bit exp_e, known, full, data_ok;
    logic [63:0] old, exp_d;
    exp_e = model_err(addr);
    known = !exp_e && mem_m.exists(key_of(addr));
    old   = known ? mem_m[key_of(addr)] : 64'd0;
    full  = (sel ? be : {4'd0, be[3:0]}) == (sel ? 8'hFF : 8'h0F);
    data_ok = exp_e || known || (wr && full);
    exp_d = exp_e ? 64'd0 : (wr ? merge(old, data, be) : old);

    @(negedge clk);
    chk("ready_idle", 64'(rdy), 64'd1);
    reqValid = 1'b1; reqWrite = wr; reqAddr = addr; reqWrData = data; reqByteEn = be;
    @(posedge clk); #1;
    reqValid  = 1'b0;
    reqWrite  = 1'($urandom);
    reqAddr   = {$urandom, $urandom};
    reqWrData = {$urandom, $urandom};
    reqByteEn = 8'($urandom);
    lat = 0;
    while (!rv && lat < 40) begin
      respReady = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    respReady = 1'b0;
    chk("latency", 64'(lat), 64'(waits() + 1));
    chk("ready_resp", 64'(rdy), 64'd0);
    chk("err", 64'(rerr), 64'(exp_e));
    if (data_ok) chk("data", rdat, exp_d);
    if (wr && !exp_e) begin
      if (data_ok) mem_m[key_of(addr)] = exp_d;
      else if (mem_m.exists(key_of(addr))) mem_m.delete(key_of(addr));
    end

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 64'd0;
      @(posedge clk); #1;
      chk("hold_valid", 64'(rv), 64'd1);
      chk("hold_ready", 64'(rdy), 64'd0);
      chk("hold_err", 64'(rerr), 64'(exp_e));
      if (data_ok) chk("hold_data", rdat, exp_d);
    end

    @(negedge clk);
    reqValid = 1'b0; respReady = 1'b1;
    @(posedge clk); #1;
    respReady = 1'b0;
    chk("valid_drop", 64'(rv), 64'd0);
    chk("ready_after", 64'(rdy), 64'd1);
  endtask

  // Full-lane write with reset on its access edge: no response, memory untouched.
  task automatic rst_access(input logic [63:0] addr, input logic [63:0] data);
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b1; reqAddr = addr; reqWrData = data; reqByteEn = 8'hFF;
    @(posedge clk); #1;
    reqValid = 1'b0;
    repeat (waits()) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_valid", 64'(rv), 64'd0);
    chk("rst_ready", 64'(rdy), 64'd1);
    chk("rst_data", rdat, 64'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic rand_txn();
    int pick;
    logic [63:0] a, d;
    pick = $urandom_range(0, 9);
    a = 64'($urandom_range(0, 15)) * 64'(wb());
    if (pick == 7) a = a + 64'($urandom_range(1, wb() - 1));
    if (pick == 8) a = a | (64'd1 << $urandom_range(13, 31));
    if (pick == 9 && sel) a = 64'd4096 + 64'($urandom_range(0, 511)) * 64'd8;
    d = {$urandom, $urandom};
    txn(1'($urandom), a, d, 8'($urandom), $urandom_range(0, 2));
  endtask

  initial begin
    sel = 1'b0; reset = 1'b1;
    reqValid = 1'b0; reqWrite = 1'b0; respReady = 1'b0;
    reqAddr = '0; reqWrData = '0; reqByteEn = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s); #1;
      chk("rst_ready", 64'(rdy), 64'd1);
      chk("rst_valid", 64'(rv), 64'd0);
      chk("rst_data", rdat, 64'd0);
      chk("rst_err", 64'(rerr), 64'd0);
    end
    sel = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    txn(1'b0, 64'h0, 64'h0, 8'h0, 0);
    txn(1'b1, 64'h10, 64'hDEADBEEF, 8'h0F, 0);
    txn(1'b1, 64'h10, 64'h000000AA, 8'h01, 0);
    txn(1'b0, 64'h10, 64'h0, 8'h0, 0);
    chk("merge_seq", mem_m[4], 64'hDEADBEAA);
    txn(1'b0, 64'h12, 64'h0, 8'h0, 0);
    txn(1'b0, 64'h2000, 64'h0, 8'h0, 0);
    for (int w = 0; w < 16; w++) if (w != 4) txn(1'b1, 64'(w * 4), {32'd0, $urandom}, 8'h0F, 0);
    txn(1'b0, 64'h0, 64'h0, 8'h0, 0);
    txn(1'b0, 64'h10, 64'h0, 8'h0, 5);
    rst_access(64'h20, 64'h12345678);
    txn(1'b0, 64'h20, 64'h0, 8'h0, 0);
    txn(1'b1, 64'h8, 64'hFFFFFFFF, 8'h00, 0);
    txn(1'b0, 64'h8, 64'h0, 8'h0, 0);
    repeat (60) rand_txn();

    sel = 1'b1;
    for (int w = 0; w < 16; w++) txn(1'b1, 64'(w * 8), {$urandom, $urandom}, 8'hFF, 0);
    txn(1'b1, 64'h8, 64'h0123456789ABCDEF, 8'hF0, 0);
    txn(1'b0, 64'h8, 64'h0, 8'h0, 0);
    txn(1'b1, 64'hFF8, 64'hA5A5A5A55A5A5A5A, 8'hFF, 0);
    txn(1'b0, 64'hFF8, 64'h0, 8'h0, 0);
    txn(1'b0, 64'h1000, 64'h0, 8'h0, 0);
    txn(1'b0, 64'h4, 64'h0, 8'h0, 2);
    rst_access(64'h18, 64'hCAFEF00D12345678);
    txn(1'b0, 64'h18, 64'h0, 8'h0, 0);
    repeat (40) rand_txn();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
